// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   writeback (W stage) and a long-latency (mul/div) unit. LL results wait in a
//   small FIFO. The pipeline normally wins. Once the FIFO head has waited
//   STARVE_LIMIT cycles, it takes the port and the W stage is stalled.
//   A pending-destination lookup lets decode stall on RAW hazards against
//   buffered LL results.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   wb_en/wb_rd/wb_data    W-stage write request (rd==0 is not a request)
//   ll_valid/ll_rd/ll_data LL result offer; ll_ready accepts it (rd==0 is dropped)
//   stall_w                W stage must hold its contents this cycle
//   chk_rs1/chk_rs2        decode source queries -> pend_rs1/pend_rs2
//   rf_we/rf_waddr/rf_wdata/rf_src  registered RF write (src 0=pipe, 1=LL)
//   fifo_count             current FIFO occupancy
module rf_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_en,
  input  logic [4:0]                 wb_rd,
  input  logic [XLEN-1:0]            wb_data,
  input  logic                       ll_valid,
  input  logic [4:0]                 ll_rd,
  input  logic [XLEN-1:0]            ll_data,
  output logic                       ll_ready,
  output logic                       stall_w,
  input  logic [4:0]                 chk_rs1,
  input  logic [4:0]                 chk_rs2,
  output logic                       pend_rs1,
  output logic                       pend_rs2,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  output logic                       rf_src,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int AGW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      r_mem_rd   [DEPTH];
  logic [XLEN-1:0] r_mem_data [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [AGW-1:0]  r_age;

  logic            r_rf_we;
  logic [4:0]      r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;
  logic            r_rf_src;

  logic w_pipe_req;
  logic w_ne;
  logic w_force;
  logic w_pop;
  logic w_grant_pipe;
  logic w_push;
  logic w_pend1;
  logic w_pend2;

  assign w_pipe_req   = wb_en && (wb_rd != 5'd0);
  assign w_ne         = (r_count != '0);
  assign w_force      = w_ne && (r_age >= AGW'(STARVE_LIMIT));
  assign w_pop        = w_force || (!w_pipe_req && w_ne);
  assign w_grant_pipe = w_pipe_req && !w_force;

  // Ready depends only on the registered count: a pop in the same cycle does
  // not open a slot until the next cycle.
  assign ll_ready = (r_count < CW'(DEPTH));
  assign w_push   = ll_valid && ll_ready && (ll_rd != 5'd0);
  assign stall_w  = w_force;

  // An entry is live when its distance from the read pointer (mod DEPTH) is
  // below the occupancy. The head being popped this cycle still reports as
  // pending; it lands in the RF one cycle later.
  always_comb begin
    w_pend1 = 1'b0;
    w_pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ({1'b0, AW'(i) - r_rd_ptr} < r_count) begin
        if ((chk_rs1 != 5'd0) && (r_mem_rd[i] == chk_rs1)) w_pend1 = 1'b1;
        if ((chk_rs2 != 5'd0) && (r_mem_rd[i] == chk_rs2)) w_pend2 = 1'b1;
      end
    end
  end

  assign pend_rs1 = w_pend1;
  assign pend_rs2 = w_pend2;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]   <= ll_rd;
      r_mem_data[r_wr_ptr] <= ll_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_age    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Age tracks how long the current head has waited; a new head restarts.
      if (!w_ne || w_pop)                    r_age <= '0;
      else if (r_age < AGW'(STARVE_LIMIT))   r_age <= r_age + AGW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_rf_src   <= 1'b0;
    end else if (w_pop) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= r_mem_rd[r_rd_ptr];
      r_rf_wdata <= r_mem_data[r_rd_ptr];
      r_rf_src   <= 1'b1;
    end else if (w_grant_pipe) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= wb_rd;
      r_rf_wdata <= wb_data;
      r_rf_src   <= 1'b0;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign rf_src     = r_rf_src;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic        stall_w;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        pend_rs1;
  logic        pend_rs2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_src;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(.XLEN(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
    .stall_w(stall_w),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .pend_rs1(pend_rs1), .pend_rs2(pend_rs2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_src(rf_src),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [4:0]  exp_rd   [5];
  logic [31:0] exp_data [5];
  logic [4:0]  got_rd   [5];
  logic [31:0] got_data [5];

  initial begin
    int n_ll;
    int acc_at;
    int stray;
    bit fire;

    rst = 1'b1; wb_en = 1'b0; wb_rd = 5'd0; wb_data = '0;
    ll_valid = 1'b0; ll_rd = 5'd0; ll_data = '0;
    chk_rs1 = 5'd11; chk_rs2 = 5'd12;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_rf_src", rf_src, 0);
    chk("rst_ll_ready", ll_ready, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_stall", stall_w, 0);
    chk("rst_pend1", pend_rs1, 0);
    chk("rst_pend2", pend_rs2, 0);

    // Pipeline-only write, then x0 write
    wb_en = 1'b1; wb_rd = 5'd10; wb_data = 32'hAAAAAAAA;
    tick();
    chk("pipe_we", rf_we, 1);
    chk("pipe_waddr", rf_waddr, 10);
    chk("pipe_wdata", rf_wdata, 32'hAAAAAAAA);
    chk("pipe_src", rf_src, 0);
    wb_rd = 5'd0; wb_data = 32'h12345678;
    tick();
    chk("x0_we", rf_we, 0);
    chk("x0_waddr_hold", rf_waddr, 10);
    chk("x0_wdata_hold", rf_wdata, 32'hAAAAAAAA);

    // LL drain in a bubble
    wb_en = 1'b0;
    ll_valid = 1'b1; ll_rd = 5'd11; ll_data = 32'hCCCCCCCC;
    #1;
    chk("ll_ready_empty", ll_ready, 1);
    tick();
    ll_valid = 1'b0;
    #1;
    chk("ll_count1", fifo_count, 1);
    chk("ll_pend1", pend_rs1, 1);
    chk("ll_pend2_other", pend_rs2, 0);
    chk("ll_no_same_cycle_pop", rf_we, 0);
    tick();
    chk("ll_we", rf_we, 1);
    chk("ll_waddr", rf_waddr, 11);
    chk("ll_wdata", rf_wdata, 32'hCCCCCCCC);
    chk("ll_src", rf_src, 1);
    chk("ll_count0", fifo_count, 0);
    chk("ll_pend1_clear", pend_rs1, 0);

    // LL result targeting x0 is accepted but never stored
    ll_valid = 1'b1; ll_rd = 5'd0; ll_data = 32'hDEADBEEF;
    #1;
    chk("llx0_ready", ll_ready, 1);
    tick();
    ll_valid = 1'b0;
    #1;
    chk("llx0_count", fifo_count, 0);
    tick();
    chk("llx0_no_write", rf_we, 0);

    // Starvation: pipeline holds the port until the head ages out
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h55555555;
    ll_valid = 1'b1; ll_rd = 5'd12; ll_data = 32'h12121212;
    tick();
    ll_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("starve_nostall_%0d", k), stall_w, 0);
      tick();
      chk($sformatf("starve_pipe_addr_%0d", k), rf_waddr, 5);
      chk($sformatf("starve_pipe_src_%0d", k), rf_src, 0);
    end
    #1;
    chk("starve_stall", stall_w, 1);
    chk("starve_pend2", pend_rs2, 1);
    tick();
    chk("starve_ll_we", rf_we, 1);
    chk("starve_ll_addr", rf_waddr, 12);
    chk("starve_ll_data", rf_wdata, 32'h12121212);
    chk("starve_ll_src", rf_src, 1);
    chk("starve_stall_drop", stall_w, 0);
    chk("starve_count0", fifo_count, 0);
    tick();
    chk("starve_pipe_again_addr", rf_waddr, 5);
    chk("starve_pipe_again_src", rf_src, 0);

    // Full / backpressure
    for (int k = 1; k <= 4; k++) begin
      ll_valid = 1'b1; ll_rd = 5'(k); ll_data = 32'hD0000000 + 32'(k);
      exp_rd[k-1] = 5'(k); exp_data[k-1] = 32'hD0000000 + 32'(k);
      tick();
    end
    exp_rd[4] = 5'd7; exp_data[4] = 32'hD0000007;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'hD0000007;
    chk_rs1 = 5'd3; chk_rs2 = 5'd0;
    #1;
    chk("full_count", fifo_count, 4);
    chk("full_ready", ll_ready, 0);
    chk("full_pend3", pend_rs1, 1);
    chk("full_pend_x0", pend_rs2, 0);
    n_ll = 0; acc_at = -1;
    for (int cyc = 0; cyc < 80 && n_ll < 5; cyc++) begin
      fire = ll_valid && ll_ready;
      tick();
      if (fire) begin
        ll_valid = 1'b0;
        acc_at = n_ll;
      end
      if (rf_we && rf_src) begin
        if (n_ll < 5) begin
          got_rd[n_ll] = rf_waddr;
          got_data[n_ll] = rf_wdata;
        end
        n_ll++;
      end
    end
    chk("full_drain_count", 64'(n_ll), 5);
    chk("full_accept_after_first_pop", 64'(acc_at), 1);
    for (int k = 0; k < 5; k++) begin
      if (k < n_ll) begin
        chk($sformatf("full_order_rd_%0d", k), got_rd[k], exp_rd[k]);
        chk($sformatf("full_order_data_%0d", k), got_data[k], exp_data[k]);
      end
    end
    chk("full_empty_after", fifo_count, 0);

    // Reset mid-operation discards buffered results
    ll_valid = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      ll_valid = 1'b1; ll_rd = 5'(20 + k); ll_data = 32'hE0000000 + 32'(k);
      tick();
    end
    ll_valid = 1'b0;
    chk_rs1 = 5'd20;
    #1;
    chk("mid_count3", fifo_count, 3);
    chk("mid_pend20", pend_rs1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wb_en = 1'b0;
    #1;
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_ready", ll_ready, 1);
    chk("mid_rst_pend", pend_rs1, 0);
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rf_we) stray++;
    end
    chk("mid_rst_no_writes", 64'(stray), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
